// File: rtl/game_logic.sv
// Tetris game controller: owns the falling piece, validates moves against an
// external 10x20 board RAM, locks pieces, clears full rows and keeps score.
module game_logic (
  input  logic       CLOCK_50,
  input  logic       resetn,
  input  logic       left_final,
  input  logic       right_final,
  input  logic       rot_final,
  input  logic       tick_gravity,
  input  logic       board_rdata,
  output logic [3:0] board_rx,
  output logic [4:0] board_ry,
  output logic       board_we,
  output logic [3:0] board_wx,
  output logic [4:0] board_wy,
  output logic       board_wdata,
  output logic [4:0] score,
  output logic       move_accept,
  output logic [3:0] cur_x,
  output logic [4:0] cur_y,
  output logic [9:0] LEDR
);

  typedef enum logic [3:0] {
    S_BOOT, S_INIT, S_SPAWN, S_PLAY, S_CHECK, S_COMMIT,
    S_LOCK, S_SCAN, S_SHIFT, S_ZERO, S_GAMEOVER
  } state_e;

  typedef enum logic [1:0] {REQ_SPAWN, REQ_GRAV, REQ_SIDE} req_e;

  state_e     state_q, state_d;
  req_e       req_q, req_d;
  logic [3:0] cur_x_q, cur_x_d, cand_x_q, cand_x_d, col_q, col_d;
  logic [4:0] cur_y_q, cur_y_d, cand_y_q, cand_y_d, row_q, row_d, sy_q, sy_d;
  logic [4:0] score_q, score_d;
  logic [1:0] rot_q, rot_d, cand_rot_q, cand_rot_d, k_q, k_d;
  logic [2:0] type_q, type_d, next_type_q, next_type_d;
  logic       ph_q, ph_d, acc_q, acc_d;

  logic [3:0] px, off;
  logic [4:0] py;
  logic [1:0] prot;
  logic [5:0] cx, cy;
  logic       fail;

  // Returns {dx,dy} of cell k for piece t after r clockwise rotations.
  function automatic logic [3:0] cell_off(input logic [2:0] t, input logic [1:0] r,
                                          input logic [1:0] k);
    logic [15:0] shp, shifted;
    logic [1:0]  dx, dy;
    logic [3:0]  res;
    case (t)
      3'd0:    shp = 16'h159D;
      3'd1:    shp = 16'h596A;
      3'd2:    shp = 16'h1596;
      3'd3:    shp = 16'h5926;
      3'd4:    shp = 16'h156A;
      3'd5:    shp = 16'h159A;
      default: shp = 16'h1592;
    endcase
    shifted = shp >> {2'd3 - k, 2'b00};
    dx = shifted[3:2];
    dy = shifted[1:0];
    case (r)
      2'd0:    res = {dx, dy};
      2'd1:    res = {2'd3 - dy, dx};
      2'd2:    res = {2'd3 - dx, 2'd3 - dy};
      default: res = {dy, 2'd3 - dx};
    endcase
    return res;
  endfunction

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      state_q     <= S_BOOT;
      req_q       <= REQ_SPAWN;
      cur_x_q     <= 4'd3;
      cur_y_q     <= '0;
      rot_q       <= '0;
      type_q      <= '0;
      next_type_q <= '0;
      cand_x_q    <= 4'd3;
      cand_y_q    <= '0;
      cand_rot_q  <= '0;
      col_q       <= '0;
      row_q       <= '0;
      sy_q        <= '0;
      k_q         <= '0;
      ph_q        <= 1'b0;
      score_q     <= '0;
      acc_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      req_q       <= req_d;
      cur_x_q     <= cur_x_d;
      cur_y_q     <= cur_y_d;
      rot_q       <= rot_d;
      type_q      <= type_d;
      next_type_q <= next_type_d;
      cand_x_q    <= cand_x_d;
      cand_y_q    <= cand_y_d;
      cand_rot_q  <= cand_rot_d;
      col_q       <= col_d;
      row_q       <= row_d;
      sy_q        <= sy_d;
      k_q         <= k_d;
      ph_q        <= ph_d;
      score_q     <= score_d;
      acc_q       <= acc_d;
    end
  end

  // LOCK writes the committed piece; CHECK probes the candidate.
  always_comb begin
    px   = (state_q == S_LOCK) ? cur_x_q : cand_x_q;
    py   = (state_q == S_LOCK) ? cur_y_q : cand_y_q;
    prot = (state_q == S_LOCK) ? rot_q   : cand_rot_q;
    off  = cell_off(type_q, prot, k_q);
    cx   = {2'b00, px} + {4'b0000, off[3:2]};
    cy   = {1'b0, py} + {4'b0000, off[1:0]};
  end

  always_comb begin
    state_d     = state_q;
    req_d       = req_q;
    cur_x_d     = cur_x_q;
    cur_y_d     = cur_y_q;
    rot_d       = rot_q;
    type_d      = type_q;
    next_type_d = next_type_q;
    cand_x_d    = cand_x_q;
    cand_y_d    = cand_y_q;
    cand_rot_d  = cand_rot_q;
    col_d       = col_q;
    row_d       = row_q;
    sy_d        = sy_q;
    k_d         = k_q;
    ph_d        = ph_q;
    score_d     = score_q;
    acc_d       = 1'b0;
    fail        = 1'b0;
    board_rx    = '0;
    board_ry    = '0;
    board_we    = 1'b0;
    board_wx    = '0;
    board_wy    = '0;
    board_wdata = 1'b0;

    unique case (state_q)
      S_BOOT: begin
        col_d   = '0;
        row_d   = '0;
        state_d = S_INIT;
      end
      S_INIT: begin
        board_we = 1'b1;
        board_wx = col_q;
        board_wy = row_q;
        if (col_q == 4'd9) begin
          col_d = '0;
          if (row_q == 5'd19) state_d = S_SPAWN;
          else                row_d   = row_q + 5'd1;
        end else begin
          col_d = col_q + 4'd1;
        end
      end
      S_SPAWN: begin
        type_d      = next_type_q;
        next_type_d = (next_type_q == 3'd6) ? '0 : next_type_q + 3'd1;
        cur_x_d     = 4'd3;
        cur_y_d     = '0;
        rot_d       = '0;
        cand_x_d    = 4'd3;
        cand_y_d    = '0;
        cand_rot_d  = '0;
        req_d       = REQ_SPAWN;
        k_d         = '0;
        ph_d        = 1'b0;
        state_d     = S_CHECK;
      end
      S_PLAY: begin
        cand_x_d   = cur_x_q;
        cand_y_d   = cur_y_q;
        cand_rot_d = rot_q;
        req_d      = REQ_SIDE;
        k_d        = '0;
        ph_d       = 1'b0;
        if (tick_gravity) begin
          cand_y_d = cur_y_q + 5'd1;
          req_d    = REQ_GRAV;
          state_d  = S_CHECK;
        end else if (rot_final) begin
          cand_rot_d = rot_q + 2'd1;
          state_d    = S_CHECK;
        end else if (left_final) begin
          cand_x_d = cur_x_q - 4'd1;
          state_d  = S_CHECK;
        end else if (right_final) begin
          cand_x_d = cur_x_q + 4'd1;
          state_d  = S_CHECK;
        end
      end
      S_CHECK: begin
        if (!ph_q) begin
          // A left move from column 0 wraps to 15 and fails here.
          if (cx > 6'd9 || cy > 6'd19) begin
            fail = 1'b1;
          end else begin
            board_rx = cx[3:0];
            board_ry = cy[4:0];
            ph_d     = 1'b1;
          end
        end else begin
          ph_d = 1'b0;
          if (board_rdata)        fail    = 1'b1;
          else if (k_q == 2'd3)   state_d = S_COMMIT;
          else                    k_d     = k_q + 2'd1;
        end
        if (fail) begin
          case (req_q)
            REQ_SPAWN: state_d = S_GAMEOVER;
            REQ_GRAV: begin
              k_d     = '0;
              state_d = S_LOCK;
            end
            default:   state_d = S_PLAY;
          endcase
        end
      end
      S_COMMIT: begin
        cur_x_d = cand_x_q;
        cur_y_d = cand_y_q;
        rot_d   = cand_rot_q;
        acc_d   = (req_q != REQ_SPAWN);
        state_d = S_PLAY;
      end
      S_LOCK: begin
        board_we    = 1'b1;
        board_wx    = cx[3:0];
        board_wy    = cy[4:0];
        board_wdata = 1'b1;
        if (k_q == 2'd3) begin
          row_d   = 5'd19;
          col_d   = '0;
          ph_d    = 1'b0;
          state_d = S_SCAN;
        end else begin
          k_d = k_q + 2'd1;
        end
      end
      S_SCAN: begin
        if (!ph_q) begin
          board_rx = col_q;
          board_ry = row_q;
          ph_d     = 1'b1;
        end else begin
          ph_d = 1'b0;
          if (!board_rdata) begin
            col_d = '0;
            if (row_q == 5'd0) state_d = S_SPAWN;
            else               row_d   = row_q - 5'd1;
          end else if (col_q == 4'd9) begin
            col_d   = '0;
            sy_d    = row_q;
            state_d = (row_q == 5'd0) ? S_ZERO : S_SHIFT;
          end else begin
            col_d = col_q + 4'd1;
          end
        end
      end
      S_SHIFT: begin
        if (!ph_q) begin
          board_rx = col_q;
          board_ry = sy_q - 5'd1;
          ph_d     = 1'b1;
        end else begin
          ph_d        = 1'b0;
          board_we    = 1'b1;
          board_wx    = col_q;
          board_wy    = sy_q;
          board_wdata = board_rdata;
          if (col_q == 4'd9) begin
            col_d = '0;
            if (sy_q == 5'd1) state_d = S_ZERO;
            else              sy_d    = sy_q - 5'd1;
          end else begin
            col_d = col_q + 4'd1;
          end
        end
      end
      S_ZERO: begin
        board_we = 1'b1;
        board_wx = col_q;
        board_wy = '0;
        if (col_q == 4'd9) begin
          // row_q is untouched so the cleared row is rescanned.
          col_d   = '0;
          ph_d    = 1'b0;
          score_d = (score_q == 5'd31) ? score_q : score_q + 5'd1;
          state_d = S_SCAN;
        end else begin
          col_d = col_q + 4'd1;
        end
      end
      S_GAMEOVER: ;
      default:    state_d = S_BOOT;
    endcase
  end

  assign score       = score_q;
  assign move_accept = acc_q;
  assign cur_x       = cur_x_q;
  assign cur_y       = cur_y_q;
  assign LEDR        = {state_q == S_GAMEOVER,
                        !(state_q inside {S_BOOT, S_PLAY, S_GAMEOVER}),
                        type_q, score_q};

endmodule

// File: tb/tb_game_logic.sv
// Directed bench for game_logic: behavioural board RAM, vector table for
// single moves, hand sequences for lock, line clear and game over.
module tb_game_logic;

  logic       clk = 1'b0;
  logic       resetn = 1'b1;
  logic       left_final = 1'b0, right_final = 1'b0, rot_final = 1'b0, tick_gravity = 1'b0;
  logic       board_rdata = 1'b0;
  logic [3:0] board_rx, board_wx, cur_x;
  logic [4:0] board_ry, board_wy, score, cur_y;
  logic       board_we, board_wdata, move_accept;
  logic [9:0] LEDR;

  always #10 clk = ~clk;

  game_logic dut (
    .CLOCK_50     (clk),
    .resetn       (resetn),
    .left_final   (left_final),
    .right_final  (right_final),
    .rot_final    (rot_final),
    .tick_gravity (tick_gravity),
    .board_rdata  (board_rdata),
    .board_rx     (board_rx),
    .board_ry     (board_ry),
    .board_we     (board_we),
    .board_wx     (board_wx),
    .board_wy     (board_wy),
    .board_wdata  (board_wdata),
    .score        (score),
    .move_accept  (move_accept),
    .cur_x        (cur_x),
    .cur_y        (cur_y),
    .LEDR         (LEDR)
  );

  // Board RAM: one-cycle read latency, write visible next cycle.
  logic mem [0:19][0:9];
  logic all_ones = 1'b0;
  logic preload  = 1'b0;

  always @(posedge clk) begin
    if (board_we && board_wx <= 4'd9 && board_wy <= 5'd19)
      mem[board_wy][board_wx] <= board_wdata;
    if (preload)
      for (int x = 0; x < 10; x++) mem[19][x] <= (x != 5);
    if (all_ones)
      board_rdata <= 1'b1;
    else if (board_rx <= 4'd9 && board_ry <= 5'd19)
      board_rdata <= mem[board_ry][board_rx];
    else
      board_rdata <= 1'b0;
  end

  int         zero_wr = 0;
  int         acc_total = 0;
  logic [3:0] ones_x[$];
  logic [4:0] ones_y[$];

  always @(negedge clk) begin
    if (board_we && !board_wdata) zero_wr++;
    if (board_we && board_wdata) begin
      ones_x.push_back(board_wx);
      ones_y.push_back(board_wy);
    end
    if (move_accept) acc_total++;
  end

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  typedef struct {
    logic       g, r, l, rt;
    int         exp_acc;
    logic [3:0] ex;
    logic [4:0] ey;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic g, r, l, rt, input int acc, input logic [3:0] x,
                     input logic [4:0] y);
    vec_t v;
    v.g = g; v.r = r; v.l = l; v.rt = rt; v.exp_acc = acc; v.ex = x; v.ey = y;
    vecs.push_back(v);
  endtask

  task automatic pulse(input logic g, r, l, rt);
    @(posedge clk); #1;
    tick_gravity = g; rot_final = r; left_final = l; right_final = rt;
    @(posedge clk); #1;
    tick_gravity = 1'b0; rot_final = 1'b0; left_final = 1'b0; right_final = 1'b0;
  endtask

  task automatic apply_vec(input string name, input vec_t v);
    int a0;
    a0 = acc_total;
    pulse(v.g, v.r, v.l, v.rt);
    repeat (30) @(negedge clk);
    chk({name, "_accept"}, acc_total - a0, v.exp_acc);
    chk({name, "_x"}, cur_x, v.ex);
    chk({name, "_y"}, cur_y, v.ey);
  endtask

  // Waits for the busy flag to rise and fall again, bounded.
  task automatic settle(input string name);
    int n;
    n = 0;
    while (!LEDR[8] && n < 100) begin @(negedge clk); n++; end
    while (LEDR[8] && n < 5000) begin @(negedge clk); n++; end
    chk({name, "_settled"}, n < 5000, 1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    resetn = 1'b0;
    repeat (3) @(negedge clk);
    @(posedge clk); #1;
    resetn = 1'b1;
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int a0, wr0, ob, ones;
    vec_t v;

    // Asynchronous reset before any clock edge.
    #3 resetn = 1'b0;
    #3;
    chk("rst_cur_x", cur_x, 3);
    chk("rst_cur_y", cur_y, 0);
    chk("rst_ledr", LEDR, 0);
    chk("rst_we", board_we, 0);
    chk("rst_accept", move_accept, 0);
    chk("rst_score", score, 0);
    chk("rst_addr", {board_rx, board_ry, board_wx, board_wy, board_wdata}, 0);
    repeat (3) @(negedge clk);
    @(posedge clk); #1;
    resetn = 1'b1;
    repeat (300) @(negedge clk);
    chk("init_zero_writes", zero_wr, 200);
    chk("spawn_x", cur_x, 3);
    chk("spawn_y", cur_y, 0);
    chk("spawn_type", LEDR[7:5], 0);
    chk("spawn_busy", LEDR[8], 0);
    chk("spawn_accept", acc_total, 0);

    // Move vectors from spawn (I, rot 0, anchor 3,0).
    add(0, 0, 1, 0, 1, 2, 0);
    add(0, 0, 0, 1, 1, 3, 0);
    add(0, 0, 1, 0, 1, 2, 0);
    add(0, 0, 1, 0, 1, 1, 0);
    add(0, 0, 1, 0, 1, 0, 0);
    add(0, 0, 1, 0, 0, 0, 0);
    for (int i = 1; i <= 6; i++) add(0, 0, 0, 1, 1, 4'(i), 0);
    add(0, 0, 0, 1, 0, 6, 0);
    add(0, 0, 1, 1, 1, 5, 0);
    add(0, 0, 1, 0, 1, 4, 0);
    add(0, 0, 1, 0, 1, 3, 0);
    add(0, 1, 0, 1, 1, 3, 0);
    add(1, 0, 1, 0, 1, 3, 1);
    for (int y = 2; y <= 16; y++) add(1, 0, 0, 0, 1, 3, 5'(y));

    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      apply_vec($sformatf("vec%0d", i), v);
    end

    // 17th gravity step locks the vertical I into column 5, rows 16..19.
    a0 = acc_total;
    ob = ones_x.size();
    pulse(1, 0, 0, 0);
    settle("lock");
    chk("lock_accept", acc_total - a0, 0);
    chk("lock_writes", ones_x.size() - ob, 4);
    if (ones_x.size() - ob == 4) begin
      for (int k = 0; k < 4; k++) begin
        chk($sformatf("lock_wx%0d", k), ones_x[ob + k], 5);
        chk($sformatf("lock_wy%0d", k), ones_y[ob + k], 16 + k);
      end
    end
    chk("o_type", LEDR[7:5], 1);
    chk("o_x", cur_x, 3);
    chk("o_y", cur_y, 0);
    chk("o_score", score, 0);

    // Line clear: row 19 filled except column 5, then drop a vertical I.
    do_reset();
    repeat (300) @(negedge clk);
    chk("clr_spawn_type", LEDR[7:5], 0);
    @(posedge clk); #1 preload = 1'b1;
    @(posedge clk); #1 preload = 1'b0;
    a0 = acc_total;
    pulse(0, 1, 0, 0);
    repeat (30) @(negedge clk);
    for (int i = 0; i < 16; i++) begin
      pulse(1, 0, 0, 0);
      repeat (30) @(negedge clk);
    end
    chk("clr_accepts", acc_total - a0, 17);
    chk("clr_drop_y", cur_y, 16);
    pulse(1, 0, 0, 0);
    settle("clear");
    chk("clr_score", score, 1);
    chk("clr_ledr_score", LEDR[4:0], 1);
    chk("clr_r19c5", mem[19][5], 1);
    chk("clr_r18c5", mem[18][5], 1);
    chk("clr_r17c5", mem[17][5], 1);
    chk("clr_r16c5", mem[16][5], 0);
    chk("clr_r19c0", mem[19][0], 0);
    ones = 0;
    for (int y = 0; y < 20; y++)
      for (int x = 0; x < 10; x++)
        if (mem[y][x] === 1'b1) ones++;
    chk("clr_ones", ones, 3);
    chk("clr_next_type", LEDR[7:5], 1);

    // Reset mid-INIT must act immediately, then a blocked spawn ends the game.
    all_ones = 1'b1;
    do_reset();
    wr0 = zero_wr;
    repeat (50) @(negedge clk);
    chk("midinit_we", board_we, 1);
    resetn = 1'b0;
    #1;
    chk("midinit_rst_we", board_we, 0);
    chk("midinit_rst_ledr", LEDR, 0);
    chk("midinit_rst_x", cur_x, 3);
    repeat (3) @(negedge clk);
    @(posedge clk); #1;
    resetn = 1'b1;
    wr0 = zero_wr;
    repeat (300) @(negedge clk);
    chk("go_init_writes", zero_wr - wr0, 200);
    chk("go_led9", LEDR[9], 1);
    chk("go_led8", LEDR[8], 0);
    chk("go_type", LEDR[7:5], 0);
    a0 = acc_total;
    pulse(0, 0, 1, 0);
    repeat (30) @(negedge clk);
    pulse(1, 0, 0, 0);
    repeat (30) @(negedge clk);
    pulse(0, 1, 0, 1);
    repeat (30) @(negedge clk);
    chk("go_no_accept", acc_total - a0, 0);
    chk("go_hold_x", cur_x, 3);
    chk("go_hold_y", cur_y, 0);
    chk("go_led9_hold", LEDR[9], 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
